// File: rtl/mem_lsu.sv
// Memory-access stage: forwards write-back for ALU ops and runs a req/ack data-bus
// transaction for loads/stores with lane selects, alignment checks and timeout.
module mem_lsu #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_i,
  input  logic [REG_ADDR_W-1:0] wd_i,
  input  logic                  wreg_i,
  input  logic [DATA_W-1:0]     wdata_i,
  input  logic [DATA_W-1:0]     hi_i,
  input  logic [DATA_W-1:0]     lo_i,
  input  logic                  whilo_i,
  input  logic [3:0]            memop_i,
  input  logic [ADDR_W-1:0]     maddr_i,
  input  logic [DATA_W-1:0]     msdata_i,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_W-1:0]     mem_addr_o,
  output logic [DATA_W/8-1:0]   mem_sel_o,
  output logic [DATA_W-1:0]     mem_wdata_o,
  input  logic [DATA_W-1:0]     mem_rdata_i,
  input  logic                  mem_ack_i,
  output logic                  stallreq_o,
  output logic [REG_ADDR_W-1:0] wd_o,
  output logic                  wreg_o,
  output logic [DATA_W-1:0]     wdata_o,
  output logic [DATA_W-1:0]     hi_o,
  output logic [DATA_W-1:0]     lo_o,
  output logic                  whilo_o,
  output logic                  align_err_o,
  output logic                  bus_err_o
);

  localparam int SEL_W = DATA_W / 8;
  localparam int OFF_W = $clog2(SEL_W);
  localparam int CNT_W = 16;

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  typedef enum logic {IDLE, WAIT} state_e;

  state_e                state_q, state_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
  logic [SEL_W-1:0]      mem_sel_q, mem_sel_d;
  logic [DATA_W-1:0]     mem_wdata_q, mem_wdata_d;
  logic [REG_ADDR_W-1:0] wd_q, wd_d;
  logic                  wreg_q, wreg_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [DATA_W-1:0]     hi_q, hi_d;
  logic [DATA_W-1:0]     lo_q, lo_d;
  logic                  whilo_q, whilo_d;
  logic                  align_err_q, align_err_d;
  logic                  bus_err_q, bus_err_d;

  // Copies of the instruction taken when the bus transaction starts
  logic [3:0]            op_h_q, op_h_d;
  logic [OFF_W-1:0]      off_h_q, off_h_d;
  logic [REG_ADDR_W-1:0] wd_h_q, wd_h_d;
  logic                  wreg_h_q, wreg_h_d;
  logic [DATA_W-1:0]     hi_h_q, hi_h_d;
  logic [DATA_W-1:0]     lo_h_q, lo_h_d;
  logic                  whilo_h_q, whilo_h_d;
  logic                  kill_q, kill_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic                  is_mem, is_store, is_load_h, aligned, timeout, kill_now;
  logic [OFF_W-1:0]      off;
  logic [SEL_W-1:0]      req_sel;
  logic [DATA_W-1:0]     req_wdata, rd_shift, load_data;

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_sel_o   = mem_sel_q;
  assign mem_wdata_o = mem_wdata_q;
  assign wd_o        = wd_q;
  assign wreg_o      = wreg_q;
  assign wdata_o     = wdata_q;
  assign hi_o        = hi_q;
  assign lo_o        = lo_q;
  assign whilo_o     = whilo_q;
  assign align_err_o = align_err_q;
  assign bus_err_o   = bus_err_q;

  // Decode of the incoming request and of the held load
  always_comb begin
    off       = maddr_i[OFF_W-1:0];
    is_mem    = (memop_i >= OP_LB) && (memop_i <= OP_SW);
    is_store  = (memop_i >= OP_SB) && (memop_i <= OP_SW);
    aligned   = 1'b1;
    req_sel   = '0;
    req_wdata = '0;
    case (memop_i)
      OP_LB, OP_LBU, OP_SB: begin
        req_sel   = SEL_W'(1) << off;
        req_wdata = {SEL_W{msdata_i[7:0]}};
      end
      OP_LH, OP_LHU, OP_SH: begin
        aligned   = ~off[0];
        req_sel   = SEL_W'(3) << off;
        req_wdata = {(SEL_W/2){msdata_i[15:0]}};
      end
      OP_LW, OP_SW: begin
        aligned   = (off == '0);
        req_sel   = '1;
        req_wdata = msdata_i;
      end
      default: ;
    endcase

    is_load_h = (op_h_q >= OP_LB) && (op_h_q <= OP_LW);
    rd_shift  = mem_rdata_i >> {off_h_q, 3'b000};
    case (op_h_q)
      OP_LB:   load_data = {{(DATA_W-8){rd_shift[7]}}, rd_shift[7:0]};
      OP_LBU:  load_data = {{(DATA_W-8){1'b0}}, rd_shift[7:0]};
      OP_LH:   load_data = {{(DATA_W-16){rd_shift[15]}}, rd_shift[15:0]};
      OP_LHU:  load_data = {{(DATA_W-16){1'b0}}, rd_shift[15:0]};
      default: load_data = mem_rdata_i;
    endcase

    timeout  = (cnt_q == CNT_W'(TIMEOUT - 1));
    kill_now = kill_q | flush_i;
  end

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_sel_d   = mem_sel_q;
    mem_wdata_d = mem_wdata_q;
    op_h_d      = op_h_q;
    off_h_d     = off_h_q;
    wd_h_d      = wd_h_q;
    wreg_h_d    = wreg_h_q;
    hi_h_d      = hi_h_q;
    lo_h_d      = lo_h_q;
    whilo_h_d   = whilo_h_q;
    kill_d      = kill_q;
    cnt_d       = cnt_q;
    wd_d        = '0;
    wreg_d      = 1'b0;
    wdata_d     = '0;
    hi_d        = '0;
    lo_d        = '0;
    whilo_d     = 1'b0;
    align_err_d = 1'b0;
    bus_err_d   = 1'b0;
    stallreq_o  = 1'b0;

    case (state_q)
      IDLE: begin
        if (flush_i || !is_mem) begin
          wd_d    = wd_i;
          wreg_d  = wreg_i & ~flush_i;
          wdata_d = wdata_i;
          hi_d    = hi_i;
          lo_d    = lo_i;
          whilo_d = whilo_i & ~flush_i;
        end else if (!aligned) begin
          align_err_d = 1'b1;
        end else begin
          stallreq_o  = 1'b1;
          mem_req_d   = 1'b1;
          mem_we_d    = is_store;
          mem_addr_d  = maddr_i & ~ADDR_W'(SEL_W - 1);
          mem_sel_d   = req_sel;
          mem_wdata_d = req_wdata;
          op_h_d      = memop_i;
          off_h_d     = off;
          wd_h_d      = wd_i;
          wreg_h_d    = wreg_i;
          hi_h_d      = hi_i;
          lo_h_d      = lo_i;
          whilo_h_d   = whilo_i;
          kill_d      = 1'b0;
          cnt_d       = '0;
          state_d     = WAIT;
        end
      end

      WAIT: begin
        stallreq_o = ~mem_ack_i & ~timeout;
        if (mem_ack_i || timeout) begin
          state_d     = IDLE;
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_addr_d  = '0;
          mem_sel_d   = '0;
          mem_wdata_d = '0;
          kill_d      = 1'b0;
          cnt_d       = '0;
        end else begin
          cnt_d  = cnt_q + CNT_W'(1);
          kill_d = kill_now;
        end
        // An ack wins over a timeout landing in the same cycle
        if (mem_ack_i) begin
          wd_d    = wd_h_q;
          wreg_d  = wreg_h_q & is_load_h & ~kill_now;
          wdata_d = is_load_h ? load_data : '0;
          hi_d    = hi_h_q;
          lo_d    = lo_h_q;
          whilo_d = whilo_h_q & ~kill_now;
        end else if (timeout) begin
          bus_err_d = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_sel_q   <= '0;
      mem_wdata_q <= '0;
      wd_q        <= '0;
      wreg_q      <= 1'b0;
      wdata_q     <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      whilo_q     <= 1'b0;
      align_err_q <= 1'b0;
      bus_err_q   <= 1'b0;
      op_h_q      <= '0;
      off_h_q     <= '0;
      wd_h_q      <= '0;
      wreg_h_q    <= 1'b0;
      hi_h_q      <= '0;
      lo_h_q      <= '0;
      whilo_h_q   <= 1'b0;
      kill_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_sel_q   <= mem_sel_d;
      mem_wdata_q <= mem_wdata_d;
      wd_q        <= wd_d;
      wreg_q      <= wreg_d;
      wdata_q     <= wdata_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      whilo_q     <= whilo_d;
      align_err_q <= align_err_d;
      bus_err_q   <= bus_err_d;
      op_h_q      <= op_h_d;
      off_h_q     <= off_h_d;
      wd_h_q      <= wd_h_d;
      wreg_h_q    <= wreg_h_d;
      hi_h_q      <= hi_h_d;
      lo_h_q      <= lo_h_d;
      whilo_h_q   <= whilo_h_d;
      kill_q      <= kill_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: directed cases from the test plan followed by
// randomized instructions checked against a transaction-level reference model.
module tb_mem_lsu;

  localparam int TOUT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_i;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [31:0] wdata_i, hi_i, lo_i;
  logic        whilo_i;
  logic [3:0]  memop_i;
  logic [31:0] maddr_i, msdata_i;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_sel_o;
  logic [31:0] mem_wdata_o, mem_rdata_i;
  logic        mem_ack_i;
  logic        stallreq_o;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o, hi_o, lo_o;
  logic        whilo_o, align_err_o, bus_err_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_lsu #(.DATA_W(32), .ADDR_W(32), .REG_ADDR_W(5), .TIMEOUT(TOUT)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
    .hi_i(hi_i), .lo_i(lo_i), .whilo_i(whilo_i),
    .memop_i(memop_i), .maddr_i(maddr_i), .msdata_i(msdata_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_sel_o(mem_sel_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
    .stallreq_o(stallreq_o),
    .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
    .hi_o(hi_o), .lo_o(lo_o), .whilo_o(whilo_o),
    .align_err_o(align_err_o), .bus_err_o(bus_err_o)
  );

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: value written back by a load of op at addr given the bus word
  function automatic logic [31:0] refLoad(input logic [3:0] op, input logic [31:0] addr,
                                          input logic [31:0] rdata);
    logic [31:0] sh;
    logic [7:0]  bt;
    logic [15:0] hw;
    sh = rdata >> (8 * addr[1:0]);
    bt = sh[7:0];
    hw = sh[15:0];
    case (op)
      4'd1:    return 32'($signed(bt));
      4'd2:    return {24'd0, bt};
      4'd3:    return 32'($signed(hw));
      4'd4:    return {16'd0, hw};
      default: return rdata;
    endcase
  endfunction

  function automatic logic [3:0] refSel(input logic [3:0] op, input logic [31:0] addr);
    case (op)
      4'd1, 4'd2, 4'd6: return 4'(1 << addr[1:0]);
      4'd3, 4'd4, 4'd7: return 4'(3 << addr[1:0]);
      default:          return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] refStoreData(input logic [3:0] op, input logic [31:0] d);
    case (op)
      4'd6:    return {4{d[7:0]}};
      4'd7:    return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_wd"}, wd_o, 0);
    checkOutput({tag, "_wreg"}, wreg_o, 0);
    checkOutput({tag, "_wdata"}, wdata_o, 0);
    checkOutput({tag, "_hi"}, hi_o, 0);
    checkOutput({tag, "_lo"}, lo_o, 0);
    checkOutput({tag, "_whilo"}, whilo_o, 0);
    checkOutput({tag, "_req"}, mem_req_o, 0);
    checkOutput({tag, "_we"}, mem_we_o, 0);
    checkOutput({tag, "_aerr"}, align_err_o, 0);
    checkOutput({tag, "_berr"}, bus_err_o, 0);
  endtask

  // Runs one instruction from issue to completion. Entered and left at posedge+1.
  // ackK: WAIT cycle carrying ack (0 = never), flushK: WAIT cycle with flush_i,
  // rstK: WAIT cycle with rst asserted.
  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                               input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                               input logic [31:0] hi, input logic [31:0] lo, input logic whilo,
                               input logic flush, input int ackK, input int flushK, input int rstK,
                               input logic [31:0] rdata);
    bit mem, st, ld, al, killed, done;
    memop_i = op; maddr_i = addr; msdata_i = sdata;
    wd_i = wd; wreg_i = wreg; wdata_i = wdata;
    hi_i = hi; lo_i = lo; whilo_i = whilo;
    flush_i = flush; mem_ack_i = 1'b0; mem_rdata_i = $urandom;
    mem = (op >= 1) && (op <= 8);
    st  = (op >= 6) && (op <= 8);
    ld  = mem && !st;
    if (op == 3 || op == 4 || op == 7) al = (addr[0] == 1'b0);
    else if (op == 5 || op == 8)       al = (addr[1:0] == 2'b00);
    else                               al = 1'b1;

    @(negedge clk);
    if (!mem || flush || !al) begin
      checkOutput("stall_idle", stallreq_o, 0);
      @(posedge clk); #1;
      checkOutput("idle_req", mem_req_o, 0);
      if (!mem || flush) begin
        checkOutput("pass_wd", wd_o, wd);
        checkOutput("pass_wreg", wreg_o, wreg & ~flush);
        checkOutput("pass_wdata", wdata_o, wdata);
        checkOutput("pass_hi", hi_o, hi);
        checkOutput("pass_lo", lo_o, lo);
        checkOutput("pass_whilo", whilo_o, whilo & ~flush);
        checkOutput("pass_aerr", align_err_o, 0);
      end else begin
        checkOutput("align_err", align_err_o, 1);
        checkOutput("align_wreg", wreg_o, 0);
      end
      checkOutput("idle_berr", bus_err_o, 0);
    end else begin
      checkOutput("stall_issue", stallreq_o, 1);
      @(posedge clk); #1;
      checkOutput("issue_req", mem_req_o, 1);
      checkOutput("issue_we", mem_we_o, st);
      checkOutput("issue_addr", mem_addr_o, addr & ~32'd3);
      checkOutput("issue_sel", mem_sel_o, refSel(op, addr));
      if (st) checkOutput("issue_wdata", mem_wdata_o, refStoreData(op, sdata));
      checkOutput("issue_wreg", wreg_o, 0);
      flush_i = 1'b0;
      killed = 1'b0;
      done = 1'b0;
      for (int k = 1; k <= TOUT && !done; k++) begin
        mem_ack_i   = (k == ackK);
        mem_rdata_i = mem_ack_i ? rdata : $urandom;
        flush_i     = (k == flushK);
        if (k == flushK) killed = 1'b1;
        if (k == rstK) begin
          rst = 1'b1;
          @(posedge clk); #1;
          rst = 1'b0;
          checkAllZero("rst_wait");
          done = 1'b1;
        end else begin
          @(negedge clk);
          checkOutput("stall_wait", stallreq_o, (k != ackK) && (k != TOUT));
          @(posedge clk); #1;
          if (k == ackK) begin
            done = 1'b1;
            checkOutput("ack_req", mem_req_o, 0);
            checkOutput("ack_wreg", wreg_o, ld & wreg & ~killed);
            if (ld) checkOutput("ack_rdata", wdata_o, refLoad(op, addr, rdata));
            checkOutput("ack_wd", wd_o, wd);
            checkOutput("ack_hi", hi_o, hi);
            checkOutput("ack_lo", lo_o, lo);
            checkOutput("ack_whilo", whilo_o, whilo & ~killed);
            checkOutput("ack_berr", bus_err_o, 0);
          end else if (k == TOUT) begin
            done = 1'b1;
            checkOutput("tout_berr", bus_err_o, 1);
            checkOutput("tout_wreg", wreg_o, 0);
            checkOutput("tout_req", mem_req_o, 0);
          end else begin
            checkOutput("hold_req", mem_req_o, 1);
            checkOutput("hold_addr", mem_addr_o, addr & ~32'd3);
            checkOutput("hold_sel", mem_sel_o, refSel(op, addr));
            checkOutput("hold_wreg", wreg_o, 0);
          end
        end
      end
      checkOutput("txn_done", done, 1);
      mem_ack_i = 1'b0;
      flush_i   = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1; flush_i = 1'b0; wd_i = '0; wreg_i = 1'b0; wdata_i = '0;
    hi_i = '0; lo_i = '0; whilo_i = 1'b0; memop_i = '0; maddr_i = '0;
    msdata_i = '0; mem_rdata_i = '0; mem_ack_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkAllZero("reset");
    rst = 1'b0;

    // Directed cases
    applyStimulus(4'd0, 32'h0, 32'h0, 5'd3, 1'b1, 32'h1234, 32'h0, 32'h0, 1'b0, 1'b0, 0, 0, 0, 32'h0);
    applyStimulus(4'd1, 32'h103, 32'h0, 5'd7, 1'b1, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 3, 0, 0, 32'h80FF_FFFF);
    checkOutput("lb_sign", wdata_o, 32'hFFFF_FF80);
    applyStimulus(4'd2, 32'h103, 32'h0, 5'd7, 1'b1, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 3, 0, 0, 32'h80FF_FFFF);
    checkOutput("lbu_zero", wdata_o, 32'h0000_0080);
    applyStimulus(4'd7, 32'h202, 32'hABCD, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 2, 0, 0, 32'h0);
    applyStimulus(4'd5, 32'h101, 32'h0, 5'd2, 1'b1, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1, 0, 0, 32'h0);
    applyStimulus(4'd5, 32'h400, 32'h0, 5'd4, 1'b1, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 0, 0, 0, 32'h0);
    applyStimulus(4'd5, 32'h404, 32'h0, 5'd5, 1'b1, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 2, 1, 0, 32'hDEAD_BEEF);
    applyStimulus(4'd3, 32'h502, 32'h0, 5'd6, 1'b1, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 3, 0, 2, 32'h0);
    applyStimulus(4'd0, 32'h0, 32'h0, 5'd9, 1'b1, 32'h55, 32'h11, 32'h22, 1'b1, 1'b0, 0, 0, 0, 32'h0);

    // Randomized instruction stream
    for (int n = 0; n < 300; n++) begin
      logic [3:0]  op;
      logic [31:0] addr;
      op   = 4'($urandom_range(0, 15));
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (op == 3 || op == 4 || op == 7) addr[0] = 1'b0;
        if (op == 5 || op == 8)            addr[1:0] = 2'b00;
      end
      applyStimulus(op, addr, $urandom, 5'($urandom), 1'($urandom), $urandom, $urandom, $urandom,
                    1'($urandom), ($urandom_range(0, 7) == 0), $urandom_range(0, 5),
                    ($urandom_range(0, 3) == 0) ? $urandom_range(1, TOUT) : 0,
                    ($urandom_range(0, 19) == 0) ? $urandom_range(1, TOUT) : 0, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
